wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_port_arbiter_if.sv | 42 ++++
 rtl/wb_hold_slot.sv | 45 ++++
 rtl/wb_port_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, source encoding and counter limit for the writeback port arbiter.
package wb_pkg;

  localparam int D_SIZE  = 32;
  localparam int RA_SIZE = 5;
  localparam int CNT_W   = 16;

  localparam logic [CNT_W-1:0] CONFLICT_MAX = 16'hFFFF;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundles the two writeback request channels, flush, the register-file write port and the conflict counter.
interface wb_port_arbiter_if #(
  parameter int d_size  = wb_pkg::D_SIZE,
  parameter int ra_size = wb_pkg::RA_SIZE
);

  logic                     a_valid;
  logic [ra_size-1:0]       a_rd;
  logic [d_size-1:0]        a_data;
  logic                     a_ready;

  logic                     m_valid;
  logic [ra_size-1:0]       m_rd;
  logic [d_size-1:0]        m_data;
  logic                     m_ready;

  logic                     flush;

  logic                     rf_we;
  logic [ra_size-1:0]       rf_waddr;
  logic [d_size-1:0]        rf_wdata;
  logic [wb_pkg::CNT_W-1:0] conflict_cnt;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  m_valid, m_rd, m_data,
    input  flush,
    output a_ready, m_ready,
    output rf_we, rf_waddr, rf_wdata,
    output conflict_cnt
  );

  modport master (
    output a_valid, a_rd, a_data,
    output m_valid, m_rd, m_data,
    output flush,
    input  a_ready, m_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  conflict_cnt
  );

endinterface

// File: rtl/wb_hold_slot.sv
// One pending writeback entry: valid bit plus destination and payload, with load and clear controls.
module wb_hold_slot
  import wb_pkg::*;
#(
  parameter int d_size  = D_SIZE,
  parameter int ra_size = RA_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [ra_size-1:0] i_rd,
  input  logic [d_size-1:0]  i_data,
  output logic               o_valid,
  output logic [ra_size-1:0] o_rd,
  output logic [d_size-1:0]  o_data
);

  logic               r_valid_p0;
  logic [ra_size-1:0] r_rd_p0;
  logic [d_size-1:0]  r_data_p0;

  // Clear wins so a flush can never be overridden by a same-cycle load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_p0 <= 1'b0;
    end else if (i_clear) begin
      r_valid_p0 <= 1'b0;
    end else if (i_load) begin
      r_valid_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_rd_p0   <= i_rd;
      r_data_p0 <= i_data;
    end
  end

  assign o_valid = r_valid_p0;
  assign o_rd    = r_rd_p0;
  assign o_data  = r_data_p0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges ALU and load writebacks into a single registered register-file write port, oldest entry first.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int d_size  = D_SIZE,
  parameter int ra_size = RA_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  wb_port_arbiter_if.slave bus
);

  logic               w_a_valid;
  logic [ra_size-1:0] w_a_rd;
  logic [d_size-1:0]  w_a_data;
  logic               w_m_valid;
  logic [ra_size-1:0] w_m_rd;
  logic [d_size-1:0]  w_m_data;

  logic               w_grant_a;
  logic               w_grant_m;
  logic               w_grant_any;
  wb_src_e            w_grant_src;
  logic [ra_size-1:0] w_grant_rd;
  logic [d_size-1:0]  w_grant_data;

  logic               w_a_ready;
  logic               w_m_ready;
  logic               w_a_fill;
  logic               w_m_fill;
  logic               w_a_clear;
  logic               w_m_clear;
  logic               w_conflict;

  logic               r_m_older;
  logic               r_wr_we_p1;
  logic [ra_size-1:0] r_wr_addr_p1;
  logic [d_size-1:0]  r_wr_data_p1;
  logic [CNT_W-1:0]   r_conflict_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CONFLICT_MAX) ? v : v + 1'b1;
  endfunction

  // ---- p0: pending slots ----
  wb_hold_slot #(.d_size(d_size), .ra_size(ra_size)) u_slot_a (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_a_fill),
    .i_clear (w_a_clear),
    .i_rd    (bus.a_rd),
    .i_data  (bus.a_data),
    .o_valid (w_a_valid),
    .o_rd    (w_a_rd),
    .o_data  (w_a_data)
  );

  wb_hold_slot #(.d_size(d_size), .ra_size(ra_size)) u_slot_m (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_m_fill),
    .i_clear (w_m_clear),
    .i_rd    (bus.m_rd),
    .i_data  (bus.m_data),
    .o_valid (w_m_valid),
    .o_rd    (w_m_rd),
    .o_data  (w_m_data)
  );

  // A flush cycle grants nothing, so the squashed entries never reach the write port.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_m = 1'b0;
    if (!bus.flush) begin
      if (w_a_valid && w_m_valid) begin
        w_grant_m = r_m_older;
        w_grant_a = ~r_m_older;
      end else begin
        w_grant_a = w_a_valid;
        w_grant_m = w_m_valid;
      end
    end
  end

  always_comb begin
    w_grant_any  = w_grant_a | w_grant_m;
    w_grant_src  = w_grant_m ? SRC_MEM : SRC_ALU;
    w_grant_rd   = (w_grant_src == SRC_MEM) ? w_m_rd   : w_a_rd;
    w_grant_data = (w_grant_src == SRC_MEM) ? w_m_data : w_a_data;
  end

  always_comb begin
    w_a_ready  = rst & ~bus.flush & (~w_a_valid | w_grant_a);
    w_m_ready  = rst & ~bus.flush & (~w_m_valid | w_grant_m);
    w_a_fill   = bus.a_valid & w_a_ready;
    w_m_fill   = bus.m_valid & w_m_ready;
    w_a_clear  = bus.flush | (w_grant_a & ~w_a_fill);
    w_m_clear  = bus.flush | (w_grant_m & ~w_m_fill);
    w_conflict = w_a_valid & w_m_valid;
  end

  // A slot refilled while the other waits becomes the younger one; a joint fill
  // puts the load first because it precedes the ALU op in program order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_older <= 1'b0;
    end else if (bus.flush) begin
      r_m_older <= 1'b0;
    end else if (w_a_fill && w_m_fill) begin
      r_m_older <= 1'b1;
    end else if (w_m_fill && w_a_valid && !w_grant_a) begin
      r_m_older <= 1'b0;
    end else if (w_a_fill && w_m_valid && !w_grant_m) begin
      r_m_older <= 1'b1;
    end
  end

  // ---- p1: register-file write port ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_we_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
      r_wr_we_p1 <= w_grant_any && (w_grant_rd != '0);
      if (w_grant_any) begin
        r_wr_addr_p1 <= w_grant_rd;
        r_wr_data_p1 <= w_grant_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict) begin
      r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end
  end

  assign bus.a_ready      = w_a_ready;
  assign bus.m_ready      = w_m_ready;
  assign bus.rf_we        = r_wr_we_p1;
  assign bus.rf_waddr     = r_wr_addr_p1;
  assign bus.rf_wdata     = r_wr_data_p1;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule
